// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined KxK signed MAC with registered adder tree, bias, ReLU and saturation
module conv_mac_pipe #(
  parameter int I_BIT_WIDTH = 8,
  parameter int K_SIZE      = 3,
  parameter int O_BIT_WIDTH = 16,
  parameter int B_BIT_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   w_load,
  input  logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]   w_in,
  input  logic [B_BIT_WIDTH-1:0]                 b_in,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [I_BIT_WIDTH*K_SIZE*K_SIZE-1:0]   in_data,
  input  logic                                   relu_en,
  input  logic                                   sat_en,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [O_BIT_WIDTH-1:0]                 out_data
);
  localparam int N     = K_SIZE * K_SIZE;
  localparam int L     = $clog2(N);
  localparam int ACC_W = 2 * I_BIT_WIDTH + L + 1;
  localparam int SW    = (ACC_W > B_BIT_WIDTH ? ACC_W : B_BIT_WIDTH) + 1;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (O_BIT_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  function automatic int cnt(int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  logic [I_BIT_WIDTH*N-1:0]       w_reg;
  logic signed [B_BIT_WIDTH-1:0]  b_reg;
  logic                           en;
  logic                           v      [0:L];
  logic                           relu_p [0:L];
  logic                           sat_p  [0:L];
  logic signed [B_BIT_WIDTH-1:0]  b_p    [0:L];
  logic signed [ACC_W-1:0]        prod   [N];
  logic signed [SW-1:0]           sum;
  logic signed [SW-1:0]           rl;
  logic [O_BIT_WIDTH-1:0]         res;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_reg <= '0;
      b_reg <= '0;
    end else if (w_load) begin
      w_reg <= w_in;
      b_reg <= b_in;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_mul
    assign prod[i] = ACC_W'($signed(in_data[I_BIT_WIDTH*i +: I_BIT_WIDTH]))
                   * ACC_W'($signed(w_reg[I_BIT_WIDTH*i +: I_BIT_WIDTH]));
  end

  // Mode bits and bias ride alongside the tree so each sample keeps its own settings
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l <= L; l++) begin
        v[l]      <= 1'b0;
        relu_p[l] <= 1'b0;
        sat_p[l]  <= 1'b0;
        b_p[l]    <= '0;
      end
    end else if (en) begin
      v[0]      <= in_valid;
      relu_p[0] <= relu_en;
      sat_p[0]  <= sat_en;
      b_p[0]    <= b_reg;
      for (int l = 1; l <= L; l++) begin
        v[l]      <= v[l-1];
        relu_p[l] <= relu_p[l-1];
        sat_p[l]  <= sat_p[l-1];
        b_p[l]    <= b_p[l-1];
      end
    end
  end

  for (genvar l = 0; l <= L; l++) begin : t
    localparam int C = cnt(l);
    logic signed [ACC_W-1:0] s  [C];
    logic signed [ACC_W-1:0] nx [C];
    if (l == 0) begin : g_m
      for (genvar j = 0; j < C; j++) begin : g_n
        assign nx[j] = prod[j];
      end
    end else begin : g_a
      localparam int P = cnt(l - 1);
      for (genvar j = 0; j < C; j++) begin : g_n
        if (2 * j + 1 < P) begin : g_add
          assign nx[j] = t[l-1].s[2*j] + t[l-1].s[2*j+1];
        end else begin : g_pass
          assign nx[j] = t[l-1].s[2*j];
        end
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) s <= '{default: '0};
      else if (en) s <= nx;
    end
  end

  // ReLU is applied before the clamp, so a negative sum with both enabled yields 0
  always_comb begin
    sum = SW'(t[L].s[0]) + SW'(b_p[L]);
    rl  = (relu_p[L] && sum < 0) ? '0 : sum;
    res = !sat_p[L] ? rl[O_BIT_WIDTH-1:0] :
          (rl > MAXV) ? MAXV[O_BIT_WIDTH-1:0] :
          (rl < MINV) ? MINV[O_BIT_WIDTH-1:0] : rl[O_BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= v[L];
      out_data  <= res;
    end
  end
endmodule
